sn_accum: RTL and testbench
===========================

SN_ACCUM -- requirements
Module: sn_accum

Interface
REQ-001 Parameter LANES, default 4: number of stochastic lanes consumed per cycle.
REQ-002 Parameter MAX_LEN, default 16: maximum accepted stream length in cycles.
REQ-003 Port i_clk_sn_acc, input, 1: single clock; all state on its rising edge.
REQ-004 Port i_rst_n_sn_acc, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_isgen, input, 1: upstream stream-generation window; high while stream bits are valid.
REQ-006 Port i_sn_bit, input, LANES: activation stream bits, one per lane, sampled when i_isgen=1.
REQ-007 Port i_w_sn_bit, input, LANES: weight stream bits, lane-aligned with i_sn_bit.
REQ-008 Port i_ready, input, 1: downstream accepts the result when high together with o_valid.
REQ-009 Port o_busy, output, 1: high in ACC state.
REQ-010 Port o_valid, output, 1: result held and offered downstream.
REQ-011 Port o_sum, output, 7: count of ones of (i_sn_bit AND i_w_sn_bit) over the stream.
REQ-012 Port o_len, output, 5: number of stream cycles accumulated, 0..MAX_LEN.
REQ-013 Port o_err, output, 1: sticky; stream overlong, or stream started while a result was held.

Function
REQ-014 The block SHALL implement states IDLE, ACC, HOLD, DRAIN.
REQ-015 Per-cycle product: pc = popcount(i_sn_bit AND i_w_sn_bit), 0..LANES, combinational.
REQ-016 IDLE and i_isgen=1: next state ACC; acc <= pc; len <= 1 (the first stream cycle is counted).
REQ-017 IDLE and i_isgen=0: no state change; acc and len unchanged.
REQ-018 ACC, i_isgen=1, len<MAX_LEN: acc <= acc+pc; len <= len+1.
REQ-019 ACC, i_isgen=1, len=MAX_LEN: bits ignored, o_err set, next state DRAIN.
REQ-020 DRAIN: remain until i_isgen=0, then next state HOLD; acc/len frozen.
REQ-021 ACC, i_isgen=0: next state HOLD; no accumulation that cycle.
REQ-022 HOLD: o_valid=1; o_sum=acc, o_len=len, both stable until handshake.
REQ-023 HOLD, i_ready=1: handshake completes on that edge; next state IDLE; o_valid low the following cycle.
REQ-024 HOLD, i_isgen=1 (new stream while result unaccepted): stream discarded, o_err set, held result unchanged.
REQ-025 HOLD, i_ready=1 and i_isgen=1 same cycle: handshake completes, stream's first cycle is NOT captured; o_err set (stream partially lost).
REQ-026 Arithmetic SHALL be unsigned; 7-bit acc never overflows (max LANES*MAX_LEN = 64).
REQ-027 Latency: o_valid asserts on the edge after the first sampled cycle with i_isgen=0 following ACC.
REQ-028 o_busy=1 exactly in ACC; DRAIN reports o_busy=0, o_valid=0.
REQ-029 o_err cleared only by reset.
REQ-030 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-031 i_rst_n_sn_acc=0 SHALL immediately force state IDLE, acc=0, len=0, o_valid=0, o_busy=0, o_sum=0, o_len=0, o_err=0, independent of clock.
REQ-032 Reset asserted mid-stream (ACC, DRAIN or HOLD) SHALL discard partial/held result; after release, the block waits in IDLE for the next i_isgen rising window.

Verification
REQ-033 Full stream: i_isgen high 16 cycles, i_sn_bit=4'b1111, i_w_sn_bit=4'b1010 each cycle, i_ready=1 -> o_valid one cycle, o_sum=32, o_len=16, o_err=0.
REQ-034 Short stream: i_isgen high 5 cycles, both inputs 4'b1111, i_ready=0 for 3 cycles then 1 -> o_sum=20, o_len=5, values stable through 4 HOLD cycles, o_valid low after handshake.
REQ-035 Overlong: i_isgen high 20 cycles, both inputs 4'b0001 -> o_sum=16, o_len=16, o_err=1 from cycle 17, o_valid only after i_isgen falls.
REQ-036 Overrun: result held (o_sum=8), i_ready=0, new 4-cycle stream arrives -> o_sum stays 8, o_err=1; after i_ready=1, IDLE.
REQ-037 Reset mid-stream: assert i_rst_n_sn_acc=0 at stream cycle 7 -> all outputs 0 asynchronously; next 16-cycle stream of 4'b1111/4'b1111 yields o_sum=64, o_len=16.
REQ-038 Zero weights: 16-cycle stream, i_w_sn_bit=4'b0000 -> o_sum=0, o_len=16, o_valid=1.

Source files
------------

// File: rtl/sn_accum.sv
// Stochastic-number MAC accumulator: sums popcount(act AND weight) over one stream window of up to MAX_LEN cycles.
// Latency: the result is offered (o_valid) on the edge after the first sampled i_isgen=0 cycle that ends the stream.
// Backpressure: the result is held until i_ready; a stream that arrives while a result is held is discarded and flags o_err.
//
// Ports:
//   i_clk_sn_acc, i_rst_n_sn_acc : clock (rising edge), asynchronous active-low reset
//   i_isgen                      : stream window, bits valid while high
//   i_sn_bit, i_w_sn_bit         : activation / weight stream bits, one per lane
//   i_ready                      : downstream accepts when high with o_valid
//   o_busy                       : accumulating (ACC state only)
//   o_valid, o_sum, o_len        : held result: ones count and stream length
//   o_err                        : sticky error (overlong stream, or stream overran a held result)
module sn_accum #(
  parameter int LANES   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic             i_clk_sn_acc,
  input  logic             i_rst_n_sn_acc,
  input  logic             i_isgen,
  input  logic [LANES-1:0] i_sn_bit,
  input  logic [LANES-1:0] i_w_sn_bit,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [6:0]       o_sum,
  output logic [4:0]       o_len,
  output logic             o_err
);

  localparam int PCW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic [6:0] acc;
  logic [4:0] len;
  logic [PCW-1:0] pc;
  logic       len_full;

  // Per-cycle product: ones in the lane-wise AND of activation and weight.
  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PCW'(i_sn_bit[i] & i_w_sn_bit[i]);
    end
  end

  assign len_full = (len == 5'(MAX_LEN));

  always_ff @(posedge i_clk_sn_acc or negedge i_rst_n_sn_acc) begin
    if (!i_rst_n_sn_acc) begin
      state   <= IDLE;
      acc     <= '0;
      len     <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_isgen) begin
            // The first stream cycle is already counted here.
            state  <= ACC;
            acc    <= 7'(pc);
            len    <= 5'd1;
            o_busy <= 1'b1;
          end
        end

        ACC: begin
          if (!i_isgen) begin
            state   <= HOLD;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
          end else if (len_full) begin
            // Overlong: drop further bits, keep the result, wait for the window to close.
            state  <= DRAIN;
            o_busy <= 1'b0;
            o_err  <= 1'b1;
          end else begin
            acc <= acc + 7'(pc);
            len <= len + 5'd1;
          end
        end

        DRAIN: begin
          if (!i_isgen) begin
            state   <= HOLD;
            o_valid <= 1'b1;
          end
        end

        HOLD: begin
          // A new stream while a result is held is always lost, at least its
          // first cycle, even when the handshake completes on the same edge.
          if (i_isgen) begin
            o_err <= 1'b1;
          end
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_sum = acc;
  assign o_len = len;

endmodule

// File: tb/tb_sn_accum.sv
module tb_sn_accum;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 16;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             isgen = 1'b0;
  logic             ready = 1'b0;
  logic [LANES-1:0] sn    = '0;
  logic [LANES-1:0] w     = '0;
  logic             busy, valid, err;
  logic [6:0]       sum;
  logic [4:0]       len;

  int n_chk  = 0;
  int n_fail = 0;
  bit err_m  = 1'b0;   // reference copy of the sticky error

  sn_accum #(.LANES(LANES), .MAX_LEN(MAX_LEN)) dut (
    .i_clk_sn_acc   (clk),
    .i_rst_n_sn_acc (rst_n),
    .i_isgen        (isgen),
    .i_sn_bit       (sn),
    .i_w_sn_bit     (w),
    .i_ready        (ready),
    .o_busy         (busy),
    .o_valid        (valid),
    .o_sum          (sum),
    .o_len          (len),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_sum"},   int'(sum),   0);
    chk({tag, "_len"},   int'(len),   0);
    chk({tag, "_err"},   int'(err),   0);
  endtask

  // One stream of n cycles followed by the hold/handshake phase.
  // The expected result is a plain sum over the accepted prefix of the stream.
  // hold_wait: cycles of i_ready=0 before the accepting cycle.
  // ovr: number of hold cycles (from the first) during which a new stream arrives.
  task automatic stream(input int n, input logic [LANES-1:0] af, input logic [LANES-1:0] wf,
                        input bit rnd, input int hold_wait, input int ovr);
    int s = 0;
    int l = 0;
    for (int i = 0; i < n; i++) begin
      sn    = rnd ? LANES'($urandom) : af;
      w     = rnd ? LANES'($urandom) : wf;
      isgen = 1'b1;
      if (i < MAX_LEN) begin
        s += $countones(sn & w);
        l++;
      end else begin
        err_m = 1'b1;
      end
      @(negedge clk);
      chk("busy_stream",  int'(busy),  int'(i < MAX_LEN));
      chk("valid_stream", int'(valid), 0);
      chk("err_stream",   int'(err),   int'(err_m));
    end
    isgen = 1'b0;
    sn    = '0;
    w     = '0;
    @(negedge clk);
    for (int k = 0; k <= hold_wait; k++) begin
      chk("valid_hold", int'(valid), 1);
      chk("busy_hold",  int'(busy),  0);
      chk("sum_hold",   int'(sum),   s);
      chk("len_hold",   int'(len),   l);
      chk("err_hold",   int'(err),   int'(err_m));
      isgen = (k < ovr);
      sn    = LANES'($urandom);
      w     = LANES'($urandom);
      ready = (k == hold_wait);
      @(negedge clk);
      if (isgen) err_m = 1'b1;
    end
    isgen = 1'b0;
    ready = 1'b0;
    sn    = '0;
    w     = '0;
    chk("valid_after_hs", int'(valid), 0);
    chk("busy_after_hs",  int'(busy),  0);
    chk("err_after_hs",   int'(err),   int'(err_m));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    err_m = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // Full stream, immediate accept: sum 32, len 16
    ready = 1'b1;
    stream(16, 4'b1111, 4'b1010, 1'b0, 0, 0);
    ready = 1'b0;

    // Short stream with 4 hold cycles: sum 20, len 5
    stream(5, 4'b1111, 4'b1111, 1'b0, 3, 0);

    // Zero weights: sum 0, len 16
    stream(16, 4'b1111, 4'b0000, 1'b0, 0, 0);

    // Overlong stream: truncated to 16, err from the 17th cycle
    stream(20, 4'b0001, 4'b0001, 1'b0, 1, 0);

    // Overrun: sum 8 held, new 4-cycle stream arrives before accept
    do_reset();
    stream(2, 4'b1111, 4'b1111, 1'b0, 5, 4);

    // Handshake and new stream on the same edge: stream's first cycle lost, err set
    do_reset();
    stream(3, 4'b0011, 4'b0111, 1'b0, 2, 3);
    @(negedge clk);
    chk("busy_lost_stream", int'(busy), 0);

    // Reset in the middle of a stream
    do_reset();
    for (int i = 0; i < 7; i++) begin
      isgen = 1'b1;
      sn    = 4'b1111;
      w     = 4'b1111;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    isgen = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    err_m = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset_idle");
    stream(16, 4'b1111, 4'b1111, 1'b0, 0, 0);

    // Randomized streams, lengths straddling MAX_LEN, random backpressure and overruns
    for (int t = 0; t < 40; t++) begin
      int n_len;
      int hw;
      int ov;
      n_len = $urandom_range(1, 20);
      hw    = $urandom_range(0, 3);
      ov    = (($urandom_range(0, 3)) == 0) ? $urandom_range(0, hw + 1) : 0;
      if (($urandom_range(0, 7)) == 0) do_reset();
      stream(n_len, '0, '0, 1'b1, hw, ov);
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        @(negedge clk);
        chk("idle_gap_valid", int'(valid), 0);
        chk("idle_gap_busy",  int'(busy),  0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
